mhvpis_ctrl: RTL

Multi-level hardware vectored priority interrupt controller for the accumulator processor.
- Latches external interrupt requests and holds the mask loaded by LMSK.
- Tracks nested in-service levels and selects the highest eligible request.
- Raises i_pending to the stage0 controller and supplies the vector address that stage0 loads into the PC after it acknowledges.
- RTI retires the active level.

---
 rtl/mhvpis_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mhvpis_ctrl.sv
// Multi-level vectored priority interrupt controller for the accumulator
// processor. Captures rising edges on the request lines and applies the
// LMSK mask. It tracks nested in-service levels and offers the highest
// eligible level to stage0 as a vector address. After stage0 acknowledges,
// that level is marked in service until stage0 retires it with RTI.
module mhvpis_ctrl #(
    parameter int         NUM_IRQ  = 4,
    parameter int         LVL_W    = 2,
    parameter logic [7:0] VEC_BASE = 8'hE0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_ld,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               int_ack,
    input  logic               rti,
    output logic               i_pending,
    output logic [7:0]         vec_out,
    output logic [LVL_W-1:0]   act_level,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [NUM_IRQ-1:0] mask_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] pend_nxt;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] isr;
    logic [NUM_IRQ-1:0] isr_nxt;
    logic [NUM_IRQ-1:0] elig;
    logic [LVL_W-1:0]   win;
    logic [LVL_W-1:0]   sel;
    logic [LVL_W-1:0]   sel_nxt;
    logic               ack_take;

    // Vector address for a level: VEC_BASE + 4*level, wrapping at 256.
    function automatic logic [7:0] vec_addr(input logic [LVL_W-1:0] lvl);
        logic [7:0] off;
        off = 8'(lvl) << 2;
        return VEC_BASE + off;
    endfunction

    // Returns v with its highest set bit cleared. A zero value passes
    // through unchanged, so RTI with nothing in service is harmless.
    function automatic logic [NUM_IRQ-1:0] clear_top(input logic [NUM_IRQ-1:0] v);
        logic [NUM_IRQ-1:0] r;
        logic               found;
        int                 idx;
        r     = v;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i]) begin
                found = 1'b1;
                idx   = i;
            end
        end
        if (found) begin
            r[idx] = 1'b0;
        end
        return r;
    endfunction

    // A new request is a 0->1 transition relative to last cycle's sample.
    assign rise = irq & ~irq_q;

    // The acknowledge only counts while a request is being offered.
    assign ack_take = (state == REQ) && int_ack;

    assign act_level  = sel;
    assign in_service = isr;
    assign mask_out   = mask;

    // A level is eligible when it is pending, unmasked and strictly above
    // every level that is currently in service.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            elig[i] = pend[i] & ~mask[i] & ((isr >> i) == '0);
        end
    end

    // Priority encoder: the highest-index eligible level wins.
    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (elig[i]) begin
                win = LVL_W'(i);
            end
        end
    end

    // Next pending/in-service values. A fresh edge on the level being
    // acknowledged re-arms it, and RTI clears the old top level before
    // the acknowledged level is added.
    always_comb begin
        pend_nxt = pend;
        isr_nxt  = rti ? clear_top(isr) : isr;
        if (ack_take) begin
            pend_nxt[sel] = 1'b0;
            isr_nxt[sel]  = 1'b1;
        end
        pend_nxt = pend_nxt | rise;
    end

    // FSM next-state and outputs. In REQ the selection tracks the current
    // winner, so a higher request arriving before the ack takes over.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        i_pending = 1'b0;
        vec_out   = 8'h00;
        case (state)
            IDLE: begin
                if (elig != '0) begin
                    state_nxt = REQ;
                    sel_nxt   = win;
                end
            end
            REQ: begin
                i_pending = 1'b1;
                vec_out   = vec_addr(sel);
                if (int_ack) begin
                    state_nxt = ACKD;
                end else if (elig == '0) begin
                    state_nxt = IDLE;
                end else begin
                    sel_nxt = win;
                end
            end
            ACKD: begin
                vec_out   = vec_addr(sel);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request line sampling for edge detection.
    always_ff @(posedge clk) begin
        if (clr) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq;
        end
    end

    // Pending and in-service registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            pend <= '0;
            isr  <= '0;
        end else begin
            pend <= pend_nxt;
            isr  <= isr_nxt;
        end
    end

    // Mask register; reset disables every level until software loads it.
    always_ff @(posedge clk) begin
        if (clr) begin
            mask <= '1;
        end else if (mask_ld) begin
            mask <= mask_in;
        end
    end

    // FSM state and selected level.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

endmodule
